// File: rtl/sq_sum_feeder_pkg.sv
// Shared widths, saturation limit and FSM state encoding for the a^2 + b^2 feeder.
package sq_sum_feeder_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;

  localparam logic [RES_W-1:0] SAT_MAX = 8'hFF;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] MUL_A   = 3'd1;
  localparam logic [2:0] MUL_B   = 3'd2;
  localparam logic [2:0] SUM     = 3'd3;
  localparam logic [2:0] WAIT_DS = 3'd4;
  localparam logic [2:0] ISSUE   = 3'd5;

endpackage

// File: rtl/sq_sum_feeder_mul4_shift_add.sv
// 4x4 iterative shift-add multiplier: one partial product per step, four steps per product.
// load_i has priority over step_i. acc_next_o is the accumulator value the current step
// produces, so the caller can capture the product on the same edge as the last step.
module mul4_shift_add
  import sq_sum_feeder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [OP_W-1:0]  mcand_i,
  input  logic [OP_W-1:0]  mplier_i,
  output logic [RES_W-1:0] acc_o,
  output logic [RES_W-1:0] acc_next_o,
  output logic             done_o
);

  logic [RES_W-1:0] mcand_q;
  logic [OP_W-1:0]  mplier_q;
  logic [RES_W-1:0] acc_q;
  logic [2:0]       cnt_q;

  assign acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o     = step_i && (cnt_q == 3'd3);
  assign acc_o      = acc_q;

  // Load clears the accumulator; each step adds the shifted multiplicand when the LSB is set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{(RES_W-OP_W){1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_next_o;
      mcand_q  <= {mcand_q[RES_W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[OP_W-1:1]};
      cnt_q    <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/sq_sum_feeder.sv
// Operand stage for the integer square-root unit: squares a and b on one shared
// multiplier, saturates a^2 + b^2 to 8 bits and issues a start pulse when the root is idle.
//
//   state   | meaning
//   IDLE    | waiting for start_i, operands latched on accept
//   MUL_A   | four shift-add steps computing a*a
//   MUL_B   | four shift-add steps computing b*b
//   SUM     | add, saturate and register y_bo / sat_o
//   WAIT_DS | hold result until the root unit reports idle
//   ISSUE   | root_start_o high for this single cycle
module sq_sum_feeder
  import sq_sum_feeder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OP_W-1:0]  a_bi,
  input  logic [OP_W-1:0]  b_bi,
  input  logic [1:0]       root_busy_i,
  output logic [RES_W-1:0] y_bo,
  output logic             root_start_o,
  output logic             sat_o,
  output logic             busy_o
);

  logic [2:0]       state_q;
  logic [OP_W-1:0]  b_q;
  logic [RES_W-1:0] a_sq_q;
  logic [RES_W-1:0] y_q;
  logic             sat_q;
  logic             start_q;

  logic             mul_load;
  logic             mul_step;
  logic             mul_done;
  logic [OP_W-1:0]  mul_mcand;
  logic [RES_W-1:0] mul_acc;
  logic [RES_W-1:0] mul_acc_next;
  logic [RES_W:0]   sum;

  assign mul_load  = ((state_q == IDLE) && start_i) || ((state_q == MUL_A) && mul_done);
  assign mul_step  = (state_q == MUL_A) || (state_q == MUL_B);
  assign mul_mcand = (state_q == IDLE) ? a_bi : b_q;

  // By SUM the multiplier accumulator holds b^2; a^2 was captured at the end of MUL_A.
  assign sum = {1'b0, a_sq_q} + {1'b0, mul_acc};

  mul4_shift_add u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (mul_load),
    .step_i     (mul_step),
    .mcand_i    (mul_mcand),
    .mplier_i   (mul_mcand),
    .acc_o      (mul_acc),
    .acc_next_o (mul_acc_next),
    .done_o     (mul_done)
  );

  // Sequencing FSM with result registers and the registered start pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      b_q     <= '0;
      a_sq_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            b_q     <= b_bi;
            state_q <= MUL_A;
          end
        end
        MUL_A: begin
          if (mul_done) begin
            a_sq_q  <= mul_acc_next;
            state_q <= MUL_B;
          end
        end
        MUL_B: begin
          if (mul_done) state_q <= SUM;
        end
        SUM: begin
          y_q     <= sum[RES_W] ? SAT_MAX : sum[RES_W-1:0];
          sat_q   <= sum[RES_W];
          state_q <= WAIT_DS;
        end
        WAIT_DS: begin
          if (root_busy_i == 2'd0) begin
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y_bo         = y_q;
  assign sat_o        = sat_q;
  assign root_start_o = start_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sq_sum_feeder.sv
// Scoreboard bench for sq_sum_feeder: stimulus pushes expected results, a monitor pops on each pulse.
module tb_sq_sum_feeder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] a_bi = '0;
  logic [3:0] b_bi = '0;
  logic [1:0] root_busy_i = '0;
  logic [7:0] y_bo;
  logic       root_start_o;
  logic       sat_o;
  logic       busy_o;

  sq_sum_feeder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .a_bi         (a_bi),
    .b_bi         (b_bi),
    .root_busy_i  (root_busy_i),
    .y_bo         (y_bo),
    .root_start_o (root_start_o),
    .sat_o        (sat_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int y;
    int sat;
    int acc_edge;
    int nbusy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pulses = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic exp_t model(input int a, input int b, input int e, input int nb);
    exp_t r;
    int s;
    s = a * a + b * b;
    r.y        = (s > 255) ? 255 : s;
    r.sat      = (s > 255) ? 1 : 0;
    r.acc_edge = e;
    r.nbusy    = nb;
    return r;
  endfunction

  // Monitor: every start pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk_i);
      if (root_start_o) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          lat = (e.nbusy > 10) ? e.nbusy : 10;
          check("y_bo", int'(y_bo), e.y);
          check("sat_o", int'(sat_o), e.sat);
          check("pulse_edge", cyc, e.acc_edge + lat);
          @(negedge clk_i);
          check("pulse_width", int'(root_start_o), 0);
          check("busy_after_issue", int'(busy_o), 0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  // Issue one transaction; downstream reports busy for nb edges starting at the accept edge.
  task automatic txn(input int a, input int b, input int nb, input bit expect_it, output int e_edge);
    wait_idle();
    @(negedge clk_i);
    start_i     = 1'b1;
    a_bi        = 4'(a);
    b_bi        = 4'(b);
    root_busy_i = (nb > 0) ? 2'(1 + $urandom_range(0, 2)) : 2'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi    = 4'($urandom_range(0, 15));
    b_bi    = 4'($urandom_range(0, 15));
    e_edge  = cyc;
    if (expect_it) exp_q.push_back(model(a, b, e_edge, nb));
    if (nb > 0) begin
      while (cyc < e_edge + nb - 1) @(negedge clk_i);
      root_busy_i = 2'd0;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  initial begin
    int e;
    int e2;
    int nb;

    repeat (3) @(negedge clk_i);
    check("rst_y", int'(y_bo), 0);
    check("rst_sat", int'(sat_o), 0);
    check("rst_start", int'(root_start_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Basic, saturating and zero cases.
    txn(3, 4, 0, 1'b1, e);
    wait_until(e + 10);
    check("busy_during_issue", int'(busy_o), 1);
    txn(15, 15, 0, 1'b1, e);
    txn(0, 0, 0, 1'b1, e);

    // Downstream busy through edge 14; result held during the wait.
    txn(5, 7, 15, 1'b1, e);
    wait_until(e + 12);
    check("y_hold_in_wait", int'(y_bo), 74);
    check("busy_in_wait", int'(busy_o), 1);

    // Start while busy is ignored.
    txn(3, 4, 0, 1'b1, e);
    wait_until(e + 3);
    start_i = 1'b1;
    a_bi    = 4'd1;
    b_bi    = 4'd1;
    @(negedge clk_i);
    start_i = 1'b0;

    // Reset in MUL_B discards the operation.
    txn(3, 4, 0, 1'b0, e);
    wait_until(e + 5);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_y", int'(y_bo), 0);
    check("midrst_sat", int'(sat_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_start", int'(root_start_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (15) @(negedge clk_i);
    txn(2, 2, 0, 1'b1, e);

    // Back-to-back with start held high: second accept two edges after the pulse.
    wait_idle();
    @(negedge clk_i);
    start_i = 1'b1;
    a_bi    = 4'd9;
    b_bi    = 4'd6;
    @(negedge clk_i);
    e = cyc;
    exp_q.push_back(model(9, 6, e, 0));
    e2 = e + 12;
    exp_q.push_back(model(9, 6, e2, 0));
    wait_until(e2);
    start_i = 1'b0;
    check("b2b_busy", int'(busy_o), 1);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), nb, 1'b1, e);
    end

    wait_idle();
    repeat (3) @(negedge clk_i);
    check("queue_drained", exp_q.size(), 0);
    check("pulse_count", n_pulses, 38);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/sq_sum_feeder.md
# sq_sum_feeder

Upstream operand stage for the integer square-root unit. It accepts two 4-bit operands, computes a² + b² with one shared shift-add multiplier, and saturates the sum to 8 bits. It then hands the result to the root unit with a one-cycle start pulse, but only while that unit reports idle. Root and feeder together compute ⌊√(a² + b²)⌋.

## Interface
- Parameters: none. Widths are fixed: operands 4 bits, result 8 bits.
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset (0 = reset asserted)
- start_i  in  1  request; sampled only in IDLE
- a_bi  in  4  operand a; latched on an accepted start
- b_bi  in  4  operand b; latched on an accepted start
- root_busy_i  in  2  downstream root state; 0 = idle, nonzero = busy
- y_bo  out  8  saturated a² + b²; drives the root x input; held until the next result
- root_start_o  out  1  one-cycle start pulse to the root unit
- sat_o  out  1  set when the true sum exceeded 255; held with y_bo
- busy_o  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE
  - MUL_A: 4 cycles, a·a
  - MUL_B: 4 cycles, b·b
  - SUM
  - WAIT_DS
  - ISSUE
- IDLE: if start_i = 1, latch a_bi/b_bi, clear the accumulator, set iteration counter = 0, go to MUL_A.
- MUL_A / MUL_B, shift-add step each cycle:
  - if the multiplier LSB = 1, acc += multiplicand (8-bit, zero-extended);
  - shift the multiplicand left 1 and the multiplier right 1; increment the counter;
  - after the 4th step, store the product (8 bits, max 225) and move on. MUL_A → MUL_B (counter reset, operand b loaded); MUL_B → SUM.
- SUM:
  - compute the 9-bit sum = a² + b² (max 450);
  - register y_bo = (sum > 255) ? 8'hFF : sum[7:0], and sat_o = sum[8];
  - go to WAIT_DS.
- WAIT_DS: stay while root_busy_i ≠ 0; when root_busy_i = 0, go to ISSUE.
- ISSUE: root_start_o = 1 for exactly this cycle, then return to IDLE. y_bo is stable during and after the pulse.
- start_i outside IDLE is ignored. It is not queued.
- Outputs y_bo and sat_o change only in SUM.

## Timing
- Reset values: y_bo = 0, sat_o = 0, root_start_o = 0, busy_o = 0, state = IDLE, accumulator and counter = 0.
- Cycle numbering: start accepted at edge 0.
  - MUL_A covers edges 1–4; MUL_B covers edges 5–8; SUM at edge 9.
  - WAIT_DS is entered at edge 9; with an idle downstream, ISSUE is entered at edge 10.
  - root_start_o is high from edge 10 to edge 11; busy_o falls at edge 11.
  - Minimum latency from start to pulse is 10 cycles; each cycle of downstream busy adds 1.
- root_start_o is registered and never high for two consecutive cycles.
- Back-to-back: start_i held high re-triggers in the first IDLE cycle after ISSUE.
- Reset mid-operation: everything returns to reset values immediately. No pulse is emitted and the partial result is discarded.
- root_busy_i changing to nonzero in the same cycle the FSM enters WAIT_DS keeps the FSM waiting.

## Structure
- Shared package (e.g. sq_sum_pkg):
  - state encoding localparams IDLE…ISSUE (3 bits);
  - OP_W = 4 and RES_W = 8;
  - SAT_MAX = 8'hFF.
- One natural sub-module: mul4_shift_add. It is a 4×4 iterative multiplier with load/step/done, instantiated once and reused for both squares.
- The top level holds the FSM, the product register for a², the adder/saturator, and the handshake.

## Test plan
- a=3, b=4, root_busy_i=0 → y_bo=25, sat_o=0, root_start_o high exactly at cycle 10, busy_o low at cycle 11.
- a=15, b=15 → true sum 450; y_bo=255, sat_o=1. Then a=0, b=0 → y_bo=0, sat_o=0.
- a=5, b=7, with root_busy_i=2 held for cycles 0–14 → pulse at cycle 15; y_bo=74 unchanged throughout the wait.
- start_i pulsed again at cycle 4 with a=1, b=1 (first run a=3, b=4) → ignored; result still 25 and only one pulse.
- rst_i driven low at cycle 6 (in MUL_B), released at cycle 8 → all outputs 0 and no pulse. A new start with a=2, b=2 gives y_bo=8.
- Chained with the root unit: a=3, b=4 → root y_bo=5; a=15, b=15 (saturated 255) → root y_bo=15.
